fb_port_arbiter: RTL

//  Owns the single port of the 320x240x16 frame-buffer BRAM and shares it

---
 rtl/fb_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_port_arbiter
//  Description : Single-port frame-buffer BRAM arbiter. Shares the port
//                between scan-out reads (never stalled), a full-screen clear
//                engine and valid/ready renderer writes.
//                Fixed priority: read > clear > renderer write.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_port_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 16,
  parameter int FB_WORDS = 76800
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_dropped,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Frame limits at address width so every comparison is unsigned.
  localparam logic [ADDR_W-1:0] FB_LIMIT  = ADDR_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color;
  logic              wr_in_range;
  logic              wr_accept;
  logic              clear_step;
  logic              clear_last;

  // Renderer is only offered slots the read port and clear engine leave free.
  assign wr_ready    = ~rd_req & (state == ST_IDLE) & ~reset;
  assign wr_accept   = wr_valid & wr_ready;
  assign wr_in_range = (wr_addr < FB_LIMIT);
  // Clear advances only in cycles the scan-out read leaves the port idle.
  assign clear_step  = (state == ST_CLEAR) & ~rd_req;
  assign clear_last  = clear_step & (clr_cnt == LAST_ADDR);
  assign rd_data     = bram_dout;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start a clear from idle, return once the last word is written.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clear_start) state_next = ST_CLEAR;
      ST_CLEAR: if (clear_last)  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output mux onto the BRAM port; writes are suppressed during reset.
  always_comb begin
    bram_addr = wr_addr;
    bram_din  = wr_data;
    bram_we   = 1'b0;
    if (rd_req) begin
      bram_addr = rd_addr;
    end else if (state == ST_CLEAR) begin
      bram_addr = clr_cnt;
      bram_din  = clr_color;
      bram_we   = 1'b1;
    end else begin
      bram_we   = wr_valid & wr_in_range;
    end
    if (reset) begin
      bram_we = 1'b0;
    end
  end

  // Clear counter, latched colour and registered status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_cnt    <= '0;
      clr_color  <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      rd_valid   <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      rd_valid   <= rd_req;
      wr_dropped <= wr_accept & ~wr_in_range;
      clear_done <= clear_last;
      if ((state == ST_IDLE) && clear_start) begin
        clr_color  <= clear_color;
        clr_cnt    <= '0;
        clear_busy <= 1'b1;
      end else if (clear_last) begin
        clr_cnt    <= '0;
        clear_busy <= 1'b0;
      end else if (clear_step) begin
        clr_cnt    <= clr_cnt + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
